// File: rtl/audio_mem_arbiter_if.sv
// CPU-side and memory-side bus of the audio/CPU data-memory arbiter.
// The arbiter takes the slave view; the CPU stage and memory together take the master view.
interface audio_mem_arbiter_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 24
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/audio_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store stage (priority) and a
// once-per-sample-period audio fetch with a starvation guard.
module audio_mem_arbiter #(
    parameter int unsigned       DATA_W     = 24,
    parameter int unsigned       ADDR_W     = 24,
    parameter int unsigned       SAMPLE_DIV = 2048,
    parameter logic [ADDR_W-1:0] BUF_A_BASE = 24'h010000,
    parameter logic [ADDR_W-1:0] BUF_B_BASE = 24'h020000,
    parameter int unsigned       BUF_LEN    = 4096,
    parameter int unsigned       MAX_WAIT   = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_audio_sel,
    audio_mem_arbiter_if.slave  io_bus,
    output logic [DATA_W-1:0]   o_sample_out,
    output logic                o_sample_valid,
    output logic                o_sample_overrun
);
    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned OFF_W  = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {TagNone, TagCpu, TagAudio} rd_tag_e;

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_audio_pend;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [OFF_W-1:0]  r_offset;
    logic              r_sel_q;
    rd_tag_e           r_rd_tag;
    logic [DATA_W-1:0] r_sample_out;
    logic              r_sample_valid;
    logic              r_sample_overrun;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_tick;
    logic              w_wait_max;
    logic              w_audio_gnt;
    logic              w_cpu_gnt;
    logic [OFF_W-1:0]  w_offset_next;
    logic [ADDR_W-1:0] w_audio_addr;

    assign w_tick       = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign w_wait_max   = (r_wait_cnt == WAIT_W'(MAX_WAIT));
    // Grants are masked during reset so the memory port stays quiet while state clears.
    assign w_audio_gnt  = ~i_reset & r_audio_pend & (~io_bus.cpu_req | w_wait_max);
    assign w_cpu_gnt    = ~i_reset & io_bus.cpu_req & ~w_audio_gnt;
    assign w_offset_next = (r_offset == OFF_W'(BUF_LEN - 1)) ? '0 : r_offset + OFF_W'(1);
    assign w_audio_addr = (r_sel_q ? BUF_B_BASE : BUF_A_BASE) + ADDR_W'(r_offset);

    assign io_bus.cpu_stall = ~i_reset & io_bus.cpu_req & ~w_cpu_gnt;
    assign io_bus.cpu_rdata = r_cpu_rdata;
    assign o_sample_out     = r_sample_out;
    assign o_sample_valid   = r_sample_valid;
    assign o_sample_overrun = r_sample_overrun;

    always_comb begin
        io_bus.mem_en    = 1'b0;
        io_bus.mem_we    = 1'b0;
        io_bus.mem_addr  = '0;
        io_bus.mem_wdata = '0;
        if (w_cpu_gnt) begin
            io_bus.mem_en    = 1'b1;
            io_bus.mem_we    = io_bus.cpu_we;
            io_bus.mem_addr  = io_bus.cpu_addr;
            io_bus.mem_wdata = io_bus.cpu_wdata;
        end else if (w_audio_gnt) begin
            io_bus.mem_en   = 1'b1;
            io_bus.mem_addr = w_audio_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt        <= '0;
            r_audio_pend     <= 1'b0;
            r_wait_cnt       <= '0;
            r_offset         <= '0;
            r_sel_q          <= i_audio_sel;
            r_rd_tag         <= TagNone;
            r_sample_out     <= '0;
            r_sample_valid   <= 1'b0;
            r_sample_overrun <= 1'b0;
            r_cpu_rdata      <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);

            // A tick coinciding with the grant re-arms the fetch instead of overrunning.
            r_sample_overrun <= w_tick & r_audio_pend & ~w_audio_gnt;
            if (w_tick) begin
                r_audio_pend <= 1'b1;
            end else if (w_audio_gnt) begin
                r_audio_pend <= 1'b0;
            end

            if (w_audio_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_audio_pend && !w_wait_max) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (i_audio_sel != r_sel_q) begin
                r_sel_q  <= i_audio_sel;
                r_offset <= '0;
            end else if (w_audio_gnt) begin
                r_offset <= w_offset_next;
            end

            if (w_cpu_gnt && !io_bus.cpu_we) begin
                r_rd_tag <= TagCpu;
            end else if (w_audio_gnt) begin
                r_rd_tag <= TagAudio;
            end else begin
                r_rd_tag <= TagNone;
            end

            r_sample_valid <= (r_rd_tag == TagAudio);
            if (r_rd_tag == TagCpu) begin
                r_cpu_rdata <= io_bus.mem_rdata;
            end
            if (r_rd_tag == TagAudio) begin
                r_sample_out <= io_bus.mem_rdata;
            end
        end
    end
endmodule
